// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// lsu_mem_master : MEM-stage load/store initiator with sub-word RMW
// Revision      : 1.0
// ============================================================================
module lsu_mem_master #(
   parameter int DEPTH = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_ILL  = 2'd3;

   logic [1:0]  state_q, state_d;
   logic        we_q, uns_q, rsp_err_q;
   logic [1:0]  size_q, lane_q;
   logic [31:0] wdata_q, rsp_data_q, mem_addr_q, mem_wdata_q;
   logic        req_bad;

   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                           input logic [1:0] lane, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{lane, 3'b000} +: 8];
      h = lane[1] ? w[31:16] : w[15:0];
      case (size)
         SZ_BYTE: extract = {{24{~uns & b[7]}}, b};
         SZ_HALF: extract = {{16{~uns & h[15]}}, h};
         default: extract = w;
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                         input logic [1:0] size, input logic [1:0] lane);
      logic [31:0] r;
      r = w;
      case (size)
         SZ_BYTE: r[{lane, 3'b000} +: 8] = wd[7:0];
         SZ_HALF: if (lane[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
         default: r = wd;
      endcase
      return r;
   endfunction

   always_comb begin
      req_bad = 1'b0;
      if (req_size == SZ_ILL)                                req_bad = 1'b1;
      else if (req_size == SZ_HALF && req_addr[0])           req_bad = 1'b1;
      else if (req_size == SZ_WORD && req_addr[1:0] != 2'b0) req_bad = 1'b1;
      else if ((req_addr >> (DEPTH + 2)) != 32'd0)           req_bad = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (req_bad)                                state_d = S_RESP;
               else if (req_we && req_size == SZ_WORD)     state_d = S_WR;
               else                                        state_d = S_RD;
            end
         end
         S_RD:    state_d = we_q ? S_WR : S_RESP;
         S_WR:    state_d = S_RESP;
         default: state_d = rsp_ready ? S_IDLE : S_RESP;
      endcase
   end

   always_comb begin
      req_ready = (state_q == S_IDLE);
      rsp_valid = (state_q == S_RESP);
      mem_wr    = (state_q == S_WR) && !rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
         size_q      <= 2'd0;
         lane_q      <= 2'd0;
         wdata_q     <= 32'd0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= 32'd0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  we_q       <= req_we;
                  uns_q      <= req_unsigned;
                  size_q     <= req_size;
                  lane_q     <= req_addr[1:0];
                  wdata_q    <= req_wdata;
                  rsp_err_q  <= req_bad;
                  rsp_data_q <= 32'd0;
                  // A rejected request leaves the memory port untouched.
                  if (!req_bad) begin
                     mem_addr_q <= {2'b00, req_addr[31:2]};
                     if (req_we && req_size == SZ_WORD) mem_wdata_q <= req_wdata;
                  end
               end
            end
            S_RD: begin
               // The read word is consumed here, so the merged word is ready for WR.
               if (we_q) mem_wdata_q <= merge(mem_rdata, wdata_q, size_q, lane_q);
               else      rsp_data_q  <= extract(mem_rdata, size_q, lane_q, uns_q);
            end
            default: ;
         endcase
      end
   end

   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
// tb_lsu_mem_master : scoreboard bench for lsu_mem_master
// Revision          : 1.0
// ============================================================================
module tb_lsu_mem_master;

   logic        clk, rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_data;
   logic        mem_wr;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem [0:1023];
   logic [32:0] exp_rsp [$];
   logic [63:0] exp_wr  [$];
   int          total = 0;
   int          bad   = 0;

   lsu_mem_master #(.DEPTH(10)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
   assign mem_rdata = mem[mem_addr[9:0]];
   always @(posedge clk) if (mem_wr) mem[mem_addr[9:0]] <= mem_wdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a response or a write.
   always @(negedge clk) begin
      logic [32:0] e;
      logic [63:0] w;
      if (rsp_valid && rsp_ready) begin
         if (exp_rsp.size() == 0) begin
            total++; bad++;
            $display("FAIL rsp_unexpected: got data %h err %b, none expected", rsp_data, rsp_err);
         end else begin
            e = exp_rsp.pop_front();
            chk("rsp_data", rsp_data, e[31:0]);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
         end
      end
      if (mem_wr) begin
         if (exp_wr.size() == 0) begin
            total++; bad++;
            $display("FAIL wr_unexpected: got addr %h data %h, none expected", mem_addr, mem_wdata);
         end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", mem_addr, w[63:32]);
            chk("wr_data", mem_wdata, w[31:0]);
         end
      end
   end

   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input logic exp_err,
                         input logic exp_w, input logic [31:0] exp_word, input int exp_lat);
      int lat;
      int n;
      n = 0;
      while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
      chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      exp_rsp.push_back({exp_err, exp_data});
      if (exp_w) exp_wr.push_back({addr >> 2, exp_word});
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      chk("latency", lat, exp_lat);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] held;
      int n;
      rst = 1'b1; rsp_ready = 1'b1; req_valid = 1'b0; req_we = 1'b0;
      req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // we size uns addr wdata | exp_data err | wr word | latency
      do_req(1, 2, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1, 32'hDEADBEEF, 2);
      do_req(0, 2, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0,        2);
      do_req(1, 0, 0, 32'h11, 32'h00000080, 32'h0,        0, 1, 32'hDEAD80EF, 3);
      do_req(0, 0, 0, 32'h11, 32'h0,        32'hFFFFFF80, 0, 0, 32'h0,        2);
      do_req(0, 0, 1, 32'h11, 32'h0,        32'h00000080, 0, 0, 32'h0,        2);
      do_req(0, 0, 0, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 0, 32'h0,        2);
      do_req(1, 1, 0, 32'h12, 32'h0000A234, 32'h0,        0, 1, 32'hA23480EF, 3);
      do_req(0, 1, 0, 32'h12, 32'h0,        32'hFFFFA234, 0, 0, 32'h0,        2);
      do_req(0, 1, 1, 32'h12, 32'h0,        32'h0000A234, 0, 0, 32'h0,        2);
      do_req(0, 1, 1, 32'h10, 32'h0,        32'h000080EF, 0, 0, 32'h0,        2);
      do_req(0, 2, 0, 32'h13, 32'h0,        32'h0,        1, 0, 32'h0,        1);
      do_req(1, 1, 0, 32'h11, 32'h0000FFFF, 32'h0,        1, 0, 32'h0,        1);
      do_req(0, 3, 0, 32'h0,  32'h0,        32'h0,        1, 0, 32'h0,        1);
      do_req(1, 2, 0, 32'h1000, 32'hFFFFFFFF, 32'h0,      1, 0, 32'h0,        1);
      do_req(0, 2, 0, 32'h10, 32'h0,        32'hA23480EF, 0, 0, 32'h0,        2);

      // Backpressure: stalled lw with a second request waiting.
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h10; req_wdata = 32'h0;
      exp_rsp.push_back({1'b0, 32'hA23480EF});
      @(posedge clk); #1;
      req_size = 2'd1; req_unsigned = 1'b1;
      exp_rsp.push_back({1'b0, 32'h000080EF});
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      held = rsp_data;
      chk("bp_first_data", held, 32'hA23480EF);
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
         chk("bp_data_stable", rsp_data, held);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 1;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk("bp_pending_latency", n, 2);
      @(posedge clk); #1;

      // Reset during the WR cycle of a word store.
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h20; req_wdata = 32'h12345678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rmid_wr_cycle", {31'd0, mem_wr}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rmid_wr_gated", {31'd0, mem_wr}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rmid_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rmid_mem_wr", {31'd0, mem_wr}, 32'd0);
      do_req(0, 2, 0, 32'h20, 32'h0, 32'h00000000, 0, 0, 32'h0, 2);

      repeat (2) @(posedge clk);
      chk("rsp_queue_drained", exp_rsp.size(), 32'd0);
      chk("wr_queue_drained", exp_wr.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
